// File: rtl/poly_fir_pkg.sv
// Shared types and the round/saturate helper for the polyphase decimating FIR.
package poly_fir_pkg;

  typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} fir_state_t;

  localparam int MAX_W = 64;

  typedef struct packed {
    logic             sat;
    logic [MAX_W-1:0] val;
  } rnd_sat_t;

  // Round-half-up, arithmetic shift, then clip to a signed out_w-bit range.
  function automatic rnd_sat_t round_sat(input logic signed [MAX_W-1:0] acc,
                                         input int shift, input int out_w);
    rnd_sat_t res;
    logic signed [MAX_W-1:0] one;
    logic signed [MAX_W-1:0] r;
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    one = 1;
    r   = acc;
    if (shift > 0) r = (acc + (one <<< (shift - 1))) >>> shift;
    hi = (one <<< (out_w - 1)) - one;
    lo = -(one <<< (out_w - 1));
    res.sat = 1'b0;
    res.val = r;
    if (r > hi) begin
      res.sat = 1'b1;
      res.val = hi;
    end else if (r < lo) begin
      res.sat = 1'b1;
      res.val = lo;
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Signed multiply-accumulate: one full-precision product per enabled cycle.
module fir_mac_unit #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] sample,
  input  logic signed [COEF_W-1:0] coef,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [DATA_W+COEF_W-1:0] prod_p0;

  assign prod_p0 = sample * coef;

  // p0 -> accumulator register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       acc <= '0;
    else if (clear)  acc <= '0;
    else if (enable) acc <= acc + ACC_W'(prod_p0);
  end

endmodule

// File: rtl/poly_decim_fir.sv
// Decimating FIR: shifts samples in while idle, then runs one serial MAC pass per DECIM inputs.
module poly_decim_fir
  import poly_fir_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 32,
  parameter int DECIM     = 2,
  parameter int ACC_W     = 40,
  parameter int OUT_SHIFT = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [DATA_W-1:0]   in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       coef_we,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0]   coef_wdata,
  output logic                       coef_ready,
  output logic signed [DATA_W-1:0]   out_data,
  output logic                       out_sat,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int TAP_W = $clog2(TAPS);
  localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [TAP_W-1:0] LAST_TAP   = TAP_W'(TAPS - 1);
  localparam logic [PH_W-1:0]  LAST_PHASE = PH_W'(DECIM - 1);

  fir_state_t               state;
  logic signed [DATA_W-1:0] dline [TAPS];
  logic signed [COEF_W-1:0] coef  [TAPS];
  logic [PH_W-1:0]          phase;
  logic [TAP_W-1:0]         tap;
  logic signed [ACC_W-1:0]  acc;
  logic                     accept;
  logic                     coef_wr;
  logic                     mac_clear;
  logic                     mac_en;
  rnd_sat_t                 rs;

  assign in_ready   = (state == IDLE) && !reset;
  assign coef_ready = (state == IDLE) && !reset;
  assign accept     = in_valid && in_ready;
  assign coef_wr    = coef_we && coef_ready;
  assign mac_clear  = accept && (phase == LAST_PHASE);
  assign mac_en     = (state == MAC);
  assign rs         = round_sat(MAX_W'(acc), OUT_SHIFT, DATA_W);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) coef[k] <= '0;
    end else if (coef_wr) begin
      coef[coef_addr] <= coef_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) dline[k] <= '0;
    end else if (accept) begin
      dline[0] <= in_data;
      for (int k = 1; k < TAPS; k++) dline[k] <= dline[k-1];
    end
  end

  fir_mac_unit #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk    (clk),
    .reset  (reset),
    .clear  (mac_clear),
    .enable (mac_en),
    .sample (dline[tap]),
    .coef   (coef[tap]),
    .acc    (acc)
  );

  // Control: the wrapping acceptance kicks off a TAPS-cycle MAC pass, then round and hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= '0;
      tap       <= '0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (phase == LAST_PHASE) begin
              phase <= '0;
              tap   <= '0;
              state <= MAC;
            end else begin
              phase <= phase + 1'b1;
            end
          end
        end
        MAC: begin
          if (tap == LAST_TAP) state <= ROUND;
          else                 tap   <= tap + 1'b1;
        end
        ROUND: begin
          out_data  <= rs.val[DATA_W-1:0];
          out_sat   <= rs.sat;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_decim_fir.sv
// Bench for poly_decim_fir: directed scenarios plus random traffic against a sum-of-products model.
module tb_poly_decim_fir;

  localparam int DATA_W    = 16;
  localparam int COEF_W    = 16;
  localparam int TAPS      = 32;
  localparam int DECIM     = 2;
  localparam int ACC_W     = 40;
  localparam int OUT_SHIFT = 15;
  localparam int TAP_W     = $clog2(TAPS);

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic                     coef_we;
  logic [TAP_W-1:0]         coef_addr;
  logic signed [COEF_W-1:0] coef_wdata;
  logic                     coef_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_sat;
  logic                     out_valid;
  logic                     out_ready;
  logic                     rand_ready;

  poly_decim_fir #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS),
    .DECIM(DECIM), .ACC_W(ACC_W), .OUT_SHIFT(OUT_SHIFT)
  ) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_ready(coef_ready),
    .out_data(out_data), .out_sat(out_sat), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int     total = 0;
  int     bad   = 0;
  longint m_coef [TAPS];
  longint m_hist [TAPS];
  int     m_phase;
  longint exp_data_q[$];
  bit     exp_sat_q[$];
  longint obs_data[$];
  bit     obs_sat[$];
  longint e_data;
  bit     e_sat;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic void model_reset();
    foreach (m_coef[k]) begin
      m_coef[k] = 0;
      m_hist[k] = 0;
    end
    m_phase = 0;
    exp_data_q.delete();
    exp_sat_q.delete();
  endfunction

  // Output = saturate(round(sum of newest-first history times coefficients))
  function automatic void model_accept(input longint s);
    longint sum, half, r, hi, lo;
    bit     sat;
    for (int k = TAPS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = s;
    m_phase++;
    if (m_phase == DECIM) begin
      m_phase = 0;
      sum = 0;
      for (int k = 0; k < TAPS; k++) sum += m_hist[k] * m_coef[k];
      half = (OUT_SHIFT > 0) ? (longint'(1) <<< (OUT_SHIFT > 0 ? OUT_SHIFT - 1 : 0)) : 0;
      r  = (sum + half) >>> OUT_SHIFT;
      hi = (longint'(1) <<< (DATA_W - 1)) - 1;
      lo = -(longint'(1) <<< (DATA_W - 1));
      sat = 1'b0;
      if (r > hi) begin r = hi; sat = 1'b1; end
      else if (r < lo) begin r = lo; sat = 1'b1; end
      exp_data_q.push_back(r);
      exp_sat_q.push_back(sat);
    end
  endfunction

  task automatic write_coef(input int addr, input longint val);
    int n = 0;
    @(negedge clk);
    while (!coef_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!coef_ready) begin
      check("coef_ready_timeout", coef_ready, 1);
      return;
    end
    coef_we    = 1'b1;
    coef_addr  = TAP_W'(addr);
    coef_wdata = COEF_W'(val);
    @(posedge clk);
    #1 coef_we = 1'b0;
    m_coef[addr] = val;
  endtask

  task automatic send(input longint s);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", in_ready, 1);
      return;
    end
    in_valid = 1'b1;
    in_data  = DATA_W'(s);
    @(posedge clk);
    #1 in_valid = 1'b0;
    model_accept(s);
  endtask

  task automatic wait_obs(input int target, input string name);
    int n = 0;
    while (obs_data.size() < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (obs_data.size() < target) check(name, obs_data.size(), target);
  endtask

  // Every handshake is checked against the model queue
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      obs_data.push_back(out_data);
      obs_sat.push_back(out_sat);
      if (exp_data_q.size() == 0) begin
        check("unexpected_output", out_valid, 0);
      end else begin
        e_data = exp_data_q.pop_front();
        e_sat  = exp_sat_q.pop_front();
        check("out_data", out_data, e_data);
        check("out_sat", out_sat, e_sat);
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, irdy_bad, vcount, n;
    longint held;
    bit held_sat;

    in_valid = 1'b0; in_data = '0; coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    out_ready = 1'b1; rand_ready = 1'b0;
    model_reset();

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_coef_ready", coef_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    @(negedge clk) reset = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_coef_ready", coef_ready, 1);

    // Impulse and latency
    obs_data.delete(); obs_sat.delete();
    write_coef(1, 16384);
    send(32767);
    send(0);
    lat = 0; irdy_bad = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) irdy_bad++;
      @(posedge clk);
      #1 lat++;
    end
    check("latency", lat, TAPS + 1);
    check("busy_in_ready", irdy_bad, 0);
    send(0);
    send(0);
    wait_obs(2, "impulse_timeout");
    if (obs_data.size() >= 2) begin
      check("impulse_out0", obs_data[0], 16384);
      check("impulse_sat0", obs_sat[0], 0);
      check("impulse_out1", obs_data[1], 0);
      check("impulse_sat1", obs_sat[1], 0);
    end

    // Positive and negative saturation
    for (int k = 0; k < TAPS; k++) write_coef(k, 32767);
    obs_data.delete(); obs_sat.delete();
    repeat (32) send(32767);
    wait_obs(16, "satpos_timeout");
    if (obs_data.size() >= 16) begin
      check("satpos_data", obs_data[15], 32767);
      check("satpos_flag", obs_sat[15], 1);
    end
    obs_data.delete(); obs_sat.delete();
    repeat (32) send(-32768);
    wait_obs(16, "satneg_timeout");
    if (obs_data.size() >= 16) begin
      check("satneg_data", obs_data[15], -32768);
      check("satneg_flag", obs_sat[15], 1);
    end

    // Backpressure
    obs_data.delete(); obs_sat.delete();
    out_ready = 1'b0;
    send(1000);
    send(-2000);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    check("bp_valid", out_valid, 1);
    held = out_data;
    held_sat = out_sat;
    repeat (10) begin
      @(posedge clk);
      #1;
      check("bp_data_stable", out_data, held);
      check("bp_sat_stable", out_sat, held_sat);
      check("bp_valid_hold", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_valid_fall", out_valid, 0);
    check("bp_idle", in_ready, 1);
    check("bp_one_xfer", obs_data.size(), 1);

    // Coefficient writes while busy are dropped
    for (int k = 0; k < TAPS; k++) write_coef(k, (k == 1) ? 16384 : 0);
    obs_data.delete(); obs_sat.delete();
    send(longint'($urandom_range(0, 65535)) - 32768);
    send(longint'($urandom_range(0, 65535)) - 32768);
    repeat (3) begin
      coef_we = 1'b1; coef_addr = TAP_W'(1); coef_wdata = '0;
      @(posedge clk);
      #1;
    end
    coef_we = 1'b0;
    wait_obs(1, "macwr_first_timeout");
    send(32767);
    send(0);
    wait_obs(2, "macwr_timeout");
    if (obs_data.size() >= 2) check("macwr_ignored", obs_data[1], 16384);

    // Reset during MAC aborts the pass
    obs_data.delete(); obs_sat.delete();
    send(12345);
    send(-321);
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_coef_ready", coef_ready, 0);
    @(negedge clk) reset = 1'b0;
    vcount = 0;
    repeat (50) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    check("abort_no_valid", vcount, 0);
    repeat (4) send(longint'($urandom_range(0, 65535)) - 32768);
    wait_obs(2, "abort_timeout");
    if (obs_data.size() >= 2) begin
      check("abort_out0", obs_data[0], 0);
      check("abort_out1", obs_data[1], 0);
    end

    // Random coefficients, samples and backpressure
    for (int k = 0; k < TAPS; k++) write_coef(k, longint'($urandom_range(0, 8191)) - 4096);
    obs_data.delete(); obs_sat.delete();
    rand_ready = 1'b1;
    repeat (40) send(longint'($urandom_range(0, 65535)) - 32768);
    wait_obs(20, "rand_timeout");
    rand_ready = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    repeat (5) @(posedge clk);
    check("rand_count", obs_data.size(), 20);
    check("rand_drained", exp_data_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
